pipe_stage_reg: RTL

- Parametrised elastic pipeline register for the cotm32 pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a packed payload plus a trap-cause vector under a valid/ready handshake.
- Supports an optional skid entry so upstream ready is fully registered.
- Global stall freezes the stage; flush replaces all contents with a NOP bubble.

---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with an optional skid entry, global stall and flush-to-bubble.
// Occupancy is tracked as EMPTY/ONE/FULL. The main entry drives the outputs, and the skid entry queues behind it.
module pipe_stage_reg #(
   parameter int                DATA_W  = 64,
   parameter int                TRAP_W  = 5,
   parameter logic [DATA_W-1:0] NOP_VAL = '0,
   parameter bit                SKID    = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [TRAP_W-1:0] i_trap,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [TRAP_W-1:0] o_trap,
   output logic              o_trap_any,
   output logic [1:0]        o_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_t;

   occ_t              r_state;
   logic [DATA_W-1:0] r_mainData;
   logic [TRAP_W-1:0] r_mainTrap;
   logic [DATA_W-1:0] r_skidData;
   logic [TRAP_W-1:0] r_skidTrap;

   logic w_mainValid;
   logic w_skidValid;
   logic w_acc;
   logic w_rel;

   assign w_mainValid = (r_state != ST_EMPTY);
   assign w_skidValid = (r_state == ST_FULL);

   // With a skid entry, ready depends only on stored state, which breaks the i_ready path upstream.
   generate
      if (SKID) begin : g_skid
         assign o_ready = !i_stall && !w_skidValid;
      end else begin : g_noskid
         assign o_ready = !i_stall && (!w_mainValid || i_ready);
      end
   endgenerate

   assign w_acc = i_valid && o_ready;
   assign w_rel = w_mainValid && i_ready && !i_stall;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_state    <= ST_EMPTY;
         r_mainData <= NOP_VAL;
         r_mainTrap <= '0;
         r_skidData <= NOP_VAL;
         r_skidTrap <= '0;
      end else if (!i_stall) begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  r_mainData <= i_data;
                  r_mainTrap <= i_trap;
                  r_state    <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_acc && w_rel) begin
                  r_mainData <= i_data;
                  r_mainTrap <= i_trap;
               end else if (w_acc && SKID) begin
                  r_skidData <= i_data;
                  r_skidTrap <= i_trap;
                  r_state    <= ST_FULL;
               end else if (w_rel) begin
                  r_state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_rel) begin
                  r_mainData <= r_skidData;
                  r_mainTrap <= r_skidTrap;
                  r_state    <= ST_ONE;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   assign o_valid    = w_mainValid;
   assign o_data     = r_mainData;
   assign o_trap     = r_mainTrap;
   assign o_trap_any = w_mainValid && (|r_mainTrap);
   assign o_count    = {1'b0, w_mainValid} + {1'b0, w_skidValid};

endmodule
